// File: rtl/sram_axi_bridge_if.sv
// AXI-lite bundle between the SRAM-style bridge (master) and the memory-side slave.
// Valid/ready rule for every channel: a transfer happens on a rising clock edge
// where both valid and ready are 1; once valid is raised, the source keeps valid
// and its payload stable until that edge, and the sink may change ready freely.
interface sram_axi_bridge_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU instruction and data SRAM-style ports onto one AXI-lite master.
// Only one transaction is in flight; the data port has priority when both request.
module sram_axi_bridge (
  input  logic                   clk,
  input  logic                   reset,
  // instruction fetch port (read only)
  input  logic                   inst_sram_req,
  input  logic [31:0]            inst_sram_addr,
  output logic                   inst_sram_addr_ok,
  output logic                   inst_sram_data_ok,
  output logic [31:0]            inst_sram_rdata,
  // data load/store port
  input  logic                   data_sram_req,
  input  logic                   data_sram_wr,
  input  logic [3:0]             data_sram_wstrb,
  input  logic [31:0]            data_sram_addr,
  input  logic [31:0]            data_sram_wdata,
  output logic                   data_sram_addr_ok,
  output logic                   data_sram_data_ok,
  output logic [31:0]            data_sram_rdata,
  // AXI-lite master side
  sram_axi_bridge_if.master      axi,
  // current FSM state, for observation only
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        owner_q, owner_d;          // 1 = data port, 0 = instruction port
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_data_ok_q, inst_data_ok_d;
  logic        data_data_ok_q, data_data_ok_d;

  // Acceptance is combinational in IDLE; the data port shadows the fetch port.
  always_comb begin
    data_sram_addr_ok = (state_q == S_IDLE) && data_sram_req;
    inst_sram_addr_ok = (state_q == S_IDLE) && inst_sram_req && !data_sram_req;
  end

  // Next-state and next-output computation for the single-outstanding FSM.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    owner_d        = owner_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_sram_req) begin
          owner_d = 1'b1;
          addr_d  = data_sram_addr;
          wdata_d = data_sram_wdata;
          wstrb_d = data_sram_wstrb;
          if (data_sram_wr) begin
            // Both write channels open together; each closes on its own handshake.
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end else if (inst_sram_req) begin
          owner_d   = 1'b0;
          addr_d    = inst_sram_addr;
          wdata_d   = 32'h0;
          wstrb_d   = 4'h0;
          state_d   = S_AR;
          arvalid_d = 1'b1;
        end
      end
      S_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          state_d  = S_IDLE;
          if (owner_q) begin
            data_rdata_d   = axi.rdata;
            data_data_ok_d = 1'b1;
          end else begin
            inst_rdata_d   = axi.rdata;
            inst_data_ok_d = 1'b1;
          end
        end
      end
      S_WR: begin
        awvalid_d = awvalid_q && !axi.awready;
        wvalid_d  = wvalid_q && !axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end
      end
      S_B: begin
        // Only the data port can store, so the response always belongs to it.
        if (axi.bvalid) begin
          bready_d       = 1'b0;
          data_data_ok_d = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      wstrb_q        <= 4'h0;
      owner_q        <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      inst_rdata_q   <= 32'h0;
      data_rdata_q   <= 32'h0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      owner_q        <= owner_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
    end
  end

  assign axi.araddr        = addr_q;
  assign axi.arvalid       = arvalid_q;
  assign axi.rready        = rready_q;
  assign axi.awaddr        = addr_q;
  assign axi.awvalid       = awvalid_q;
  assign axi.wdata         = wdata_q;
  assign axi.wstrb         = wstrb_q;
  assign axi.wvalid        = wvalid_q;
  assign axi.bready        = bready_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign inst_sram_data_ok = inst_data_ok_q;
  assign data_sram_rdata   = data_rdata_q;
  assign data_sram_data_ok = data_data_ok_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI-lite slave cycle by
// cycle and checks every output against hand-computed values.
module tb_sram_axi_bridge;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  sram_axi_bridge_if axi_if ();

  sram_axi_bridge dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .axi               (axi_if.master),
    .dbg_state         (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave side of one read; entered in the cycle the request is being accepted.
  task automatic serve_read(input string tag, input logic [31:0] exp_addr, input int ar_wait,
                            input logic [31:0] rd, input bit is_data, input bit keep_inst);
    tick();
    data_sram_req = 1'b0;
    if (!keep_inst) inst_sram_req = 1'b0;
    #1;
    for (int i = 0; i < ar_wait; i++) begin
      check({tag, "_arvalid_wait"}, 32'(axi_if.arvalid), 1);
      check({tag, "_araddr_wait"}, axi_if.araddr, exp_addr);
      check({tag, "_addr_ok_busy"}, 32'(inst_sram_addr_ok | data_sram_addr_ok), 0);
      check({tag, "_data_ok_early"}, 32'(inst_sram_data_ok | data_sram_data_ok), 0);
      tick();
    end
    check({tag, "_arvalid"}, 32'(axi_if.arvalid), 1);
    check({tag, "_araddr"}, axi_if.araddr, exp_addr);
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
    #1;
    check({tag, "_arvalid_drop"}, 32'(axi_if.arvalid), 0);
    check({tag, "_rready"}, 32'(axi_if.rready), 1);
    check({tag, "_addr_ok_in_r"}, 32'(inst_sram_addr_ok | data_sram_addr_ok), 0);
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = rd;
    tick();
    axi_if.rvalid = 1'b0;
    axi_if.rdata  = 32'h0;
    #1;
    if (is_data) begin
      check({tag, "_data_ok"}, 32'(data_sram_data_ok), 1);
      check({tag, "_inst_ok_quiet"}, 32'(inst_sram_data_ok), 0);
      check({tag, "_data_rdata"}, data_sram_rdata, rd);
    end else begin
      check({tag, "_inst_ok"}, 32'(inst_sram_data_ok), 1);
      check({tag, "_data_ok_quiet"}, 32'(data_sram_data_ok), 0);
      check({tag, "_inst_rdata"}, inst_sram_rdata, rd);
    end
    check({tag, "_rready_drop"}, 32'(axi_if.rready), 0);
    check({tag, "_idle"}, 32'(dbg_state), 0);
  endtask

  initial begin
    reset           = 1'b1;
    inst_sram_req   = 1'b0;
    inst_sram_addr  = 32'h0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_wstrb = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    axi_if.arready  = 1'b0;
    axi_if.rdata    = 32'h0;
    axi_if.rvalid   = 1'b0;
    axi_if.awready  = 1'b0;
    axi_if.wready   = 1'b0;
    axi_if.bvalid   = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_state", 32'(dbg_state), 0);
    check("rst_valids", 32'({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid}), 0);
    check("rst_readys", 32'({axi_if.rready, axi_if.bready}), 0);
    check("rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
    check("rst_inst_rdata", inst_sram_rdata, 32'h0);
    check("rst_data_rdata", data_sram_rdata, 32'h0);
    check("rst_araddr", axi_if.araddr, 32'h0);
    reset = 1'b0;
    tick();

    // load through a zero-wait slave
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h1c000100;
    #1;
    check("load_addr_ok", 32'(data_sram_addr_ok), 1);
    check("load_inst_addr_ok", 32'(inst_sram_addr_ok), 0);
    serve_read("load", 32'h1c000100, 0, 32'hdeadbeef, 1'b1, 1'b0);
    tick();
    check("load_data_ok_once", 32'(data_sram_data_ok), 0);
    check("load_rdata_hold", data_sram_rdata, 32'hdeadbeef);

    // simultaneous requests: data first, fetch only after data_ok
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000040;
    data_sram_req  = 1'b1;
    data_sram_addr = 32'h00000200;
    #1;
    check("arb_data_wins", 32'(data_sram_addr_ok), 1);
    check("arb_inst_loses", 32'(inst_sram_addr_ok), 0);
    serve_read("arb_data", 32'h00000200, 2, 32'h0badf00d, 1'b1, 1'b1);
    check("arb_inst_addr_ok_now", 32'(inst_sram_addr_ok), 1);
    serve_read("arb_inst", 32'h1c000040, 0, 32'h24020001, 1'b0, 1'b0);
    check("arb_data_rdata_hold", data_sram_rdata, 32'h0badf00d);
    tick();

    // store with AW accepted before W
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_addr  = 32'h00000100;
    data_sram_wdata = 32'h12345678;
    data_sram_wstrb = 4'b0011;
    #1;
    check("st_addr_ok", 32'(data_sram_addr_ok), 1);
    tick();
    data_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    #1;
    check("st_c1_awvalid", 32'(axi_if.awvalid), 1);
    check("st_c1_wvalid", 32'(axi_if.wvalid), 1);
    check("st_awaddr", axi_if.awaddr, 32'h00000100);
    check("st_wdata", axi_if.wdata, 32'h12345678);
    check("st_wstrb", 32'(axi_if.wstrb), 32'h3);
    axi_if.awready = 1'b1;
    tick();
    axi_if.awready = 1'b0;
    #1;
    check("st_c2_awvalid", 32'(axi_if.awvalid), 0);
    check("st_c2_wvalid", 32'(axi_if.wvalid), 1);
    check("st_c2_addr_ok", 32'(data_sram_addr_ok), 0);
    tick();
    check("st_c3_wvalid", 32'(axi_if.wvalid), 1);
    check("st_c3_bready", 32'(axi_if.bready), 0);
    axi_if.wready = 1'b1;
    tick();
    axi_if.wready = 1'b0;
    #1;
    check("st_c4_wvalid", 32'(axi_if.wvalid), 0);
    check("st_c4_bready", 32'(axi_if.bready), 1);
    check("st_c4_data_ok", 32'(data_sram_data_ok), 0);
    axi_if.bvalid = 1'b1;
    tick();
    axi_if.bvalid = 1'b0;
    #1;
    check("st_data_ok", 32'(data_sram_data_ok), 1);
    check("st_bready_drop", 32'(axi_if.bready), 0);
    check("st_idle", 32'(dbg_state), 0);
    tick();
    check("st_data_ok_once", 32'(data_sram_data_ok), 0);

    // zero-strobe store, both write channels accepted together
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_addr  = 32'h00000204;
    data_sram_wdata = 32'hcafef00d;
    data_sram_wstrb = 4'b0000;
    #1;
    check("st0_addr_ok", 32'(data_sram_addr_ok), 1);
    tick();
    data_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    #1;
    check("st0_awvalid", 32'(axi_if.awvalid), 1);
    check("st0_wvalid", 32'(axi_if.wvalid), 1);
    check("st0_wstrb", 32'(axi_if.wstrb), 0);
    axi_if.awready = 1'b1;
    axi_if.wready  = 1'b1;
    tick();
    axi_if.awready = 1'b0;
    axi_if.wready  = 1'b0;
    #1;
    check("st0_valids_drop", 32'({axi_if.awvalid, axi_if.wvalid}), 0);
    check("st0_bready", 32'(axi_if.bready), 1);
    axi_if.bvalid = 1'b1;
    tick();
    axi_if.bvalid = 1'b0;
    #1;
    check("st0_data_ok", 32'(data_sram_data_ok), 1);
    tick();

    // arready held low for five cycles
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h00000300;
    #1;
    check("stall_addr_ok", 32'(data_sram_addr_ok), 1);
    serve_read("stall", 32'h00000300, 5, 32'h55aa33cc, 1'b1, 1'b0);
    tick();

    // reset pulsed while waiting in R
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000080;
    #1;
    check("rr_addr_ok", 32'(inst_sram_addr_ok), 1);
    tick();
    inst_sram_req = 1'b0;
    #1;
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
    #1;
    check("rr_in_r", 32'(dbg_state), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rr_state", 32'(dbg_state), 0);
    check("rr_valids", 32'({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid}), 0);
    check("rr_readys", 32'({axi_if.rready, axi_if.bready}), 0);
    check("rr_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
    check("rr_addr_ok_quiet", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
    check("rr_inst_rdata", inst_sram_rdata, 32'h0);
    check("rr_data_rdata", data_sram_rdata, 32'h0);
    tick();
    check("rr_no_late_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);

    // fetch after reset completes normally
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000000;
    #1;
    check("post_addr_ok", 32'(inst_sram_addr_ok), 1);
    serve_read("post", 32'h1c000000, 1, 32'h3c1c0001, 1'b0, 1'b0);
    tick();
    check("post_ok_once", 32'(inst_sram_data_ok), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
